// File: rtl/sensor_seq_pkg.sv
// sensor_seq_pkg: shared state encoding, sentinel and sizing helpers for the ADC sequencer
package sensor_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_STROBE,
    S_WAIT_CONV,
    S_WAIT_LOW,
    S_STORE,
    S_FINISH
  } state_e;
  localparam logic [63:0] TIMEOUT_SENTINEL = '1;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sensor_adc_sequencer_result_buffer.sv
// channel_result_buffer: per-channel result registers with bounds-checked combinational read
module channel_result_buffer #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_data_o
);
  logic [W-1:0] mem_q [N];
  // store one averaged result per channel; cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end
  // out-of-range indices read as zero
  always_comb rd_data_o = int'(rd_idx_i) < N ? mem_q[rd_idx_i] : '0;
endmodule

// File: rtl/sensor_adc_sequencer.sv
// sensor_adc_sequencer: scans masked sensor channels through one ADC with settle, averaging and timeout
module sensor_adc_sequencer
  import sensor_seq_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int ADC_WIDTH      = 16,
  parameter int AVG_LOG2       = 2,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic [NUM_CHANNELS-1:0]            channel_mask_i,
  input  logic [2:0]                         config_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [NUM_CHANNELS-1:0]            timeout_err_o,
  input  logic [idx_w(NUM_CHANNELS)-1:0]     rd_channel_i,
  output logic [ADC_WIDTH-1:0]               rd_data_o,
  output logic [2:0]                         sens_config_o,
  output logic [NUM_CHANNELS-1:0]            sens_enable_o,
  output logic                               sens_read_o,
  output logic                               adc_enable_o,
  output logic                               adc_read_o,
  input  logic                               adc_conversion_complete_i,
  input  logic [ADC_WIDTH-1:0]               adc_value_i
);
  localparam int IW = idx_w(NUM_CHANNELS);
  localparam int AW = ADC_WIDTH + AVG_LOG2;
  localparam int CW = $clog2(TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES) + 1;
  localparam logic [AVG_LOG2:0] NSAMP = (AVG_LOG2 + 1)'(1) << AVG_LOG2;

  state_e                  state_q;
  logic [NUM_CHANNELS-1:0] pend_q, rem_d, sens_enable_q, timeout_err_q;
  logic [IW-1:0]           ch_q, first_d, next_d;
  logic [AW-1:0]           acc_q;
  logic [AVG_LOG2:0]       smp_q;
  logic [CW-1:0]           cnt_q;
  logic                    tout_q, busy_q, done_q, sens_read_q, adc_read_q, adc_enable_q;
  logic [2:0]              sens_config_q;
  logic                    wr_en_d;
  logic [ADC_WIDTH-1:0]    wr_data_d;

  function automatic logic [IW-1:0] lowest(input logic [NUM_CHANNELS-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) if (m[i]) r = IW'(i);
    return r;
  endfunction

  // channel selection and result write-back; abort suppresses the store of the in-progress channel
  always_comb begin
    rem_d     = pend_q & ~(NUM_CHANNELS'(1) << ch_q);
    first_d   = lowest(channel_mask_i);
    next_d    = lowest(rem_d);
    wr_en_d   = state_q == S_STORE && !abort_i;
    wr_data_d = tout_q ? ADC_WIDTH'(TIMEOUT_SENTINEL) : ADC_WIDTH'(acc_q >> AVG_LOG2);
  end

  // scan controller with registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      ch_q          <= '0;
      acc_q         <= '0;
      smp_q         <= '0;
      cnt_q         <= '0;
      tout_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= '0;
      sens_config_q <= '0;
      sens_enable_q <= '0;
      sens_read_q   <= 1'b0;
      adc_read_q    <= 1'b0;
      adc_enable_q  <= 1'b0;
    end else if (abort_i) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sens_config_q <= '0;
      sens_enable_q <= '0;
      sens_read_q   <= 1'b0;
      adc_read_q    <= 1'b0;
      adc_enable_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      sens_read_q <= 1'b0;
      adc_read_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          pend_q        <= channel_mask_i;
          sens_config_q <= config_i;
          timeout_err_q <= '0;
          busy_q        <= 1'b1;
          acc_q         <= '0;
          smp_q         <= '0;
          cnt_q         <= '0;
          tout_q        <= 1'b0;
          if (|channel_mask_i) begin
            ch_q          <= first_d;
            sens_enable_q <= NUM_CHANNELS'(1) << first_d;
            adc_enable_q  <= 1'b1;
            state_q       <= S_SETTLE;
          end else begin
            state_q <= S_FINISH;
          end
        end
        S_SETTLE: if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          sens_read_q <= 1'b1;
          adc_read_q  <= 1'b1;
          state_q     <= S_STROBE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        S_STROBE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_CONV;
        end
        S_WAIT_CONV: if (adc_conversion_complete_i) begin
          acc_q   <= acc_q + AW'(adc_value_i);
          smp_q   <= smp_q + (AVG_LOG2 + 1)'(1);
          state_q <= S_WAIT_LOW;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_q[ch_q] <= 1'b1;
          tout_q              <= 1'b1;
          sens_enable_q       <= '0;
          adc_enable_q        <= 1'b0;
          state_q             <= S_STORE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        S_WAIT_LOW: if (!adc_conversion_complete_i) begin
          if (smp_q == NSAMP) begin
            sens_enable_q <= '0;
            adc_enable_q  <= 1'b0;
            state_q       <= S_STORE;
          end else begin
            sens_read_q <= 1'b1;
            adc_read_q  <= 1'b1;
            state_q     <= S_STROBE;
          end
        end
        S_STORE: begin
          acc_q  <= '0;
          smp_q  <= '0;
          cnt_q  <= '0;
          tout_q <= 1'b0;
          pend_q <= rem_d;
          if (|rem_d) begin
            ch_q          <= next_d;
            sens_enable_q <= NUM_CHANNELS'(1) << next_d;
            adc_enable_q  <= 1'b1;
            state_q       <= S_SETTLE;
          end else begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  channel_result_buffer #(.N(NUM_CHANNELS), .W(ADC_WIDTH), .IW(IW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_d),
    .wr_idx_i  (ch_q),
    .wr_data_i (wr_data_d),
    .rd_idx_i  (rd_channel_i),
    .rd_data_o (rd_data_o)
  );

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = timeout_err_q;
  assign sens_config_o = sens_config_q;
  assign sens_enable_o = sens_enable_q;
  assign sens_read_o   = sens_read_q;
  assign adc_enable_o  = adc_enable_q;
  assign adc_read_o    = adc_read_q;
endmodule
